// File: rtl/sklansky_pkg.sv
// Shared constants and elaboration helpers for the pipelined Sklansky adder.
package sklansky_pkg;

  localparam int unsigned MaxWidth = 64;

  // Bit w set <=> w is a supported operand width.
  localparam logic [MaxWidth:0] LegalWidthMask =
      (65'd1 << 4) | (65'd1 << 8) | (65'd1 << 16) | (65'd1 << 32) | (65'd1 << 64);

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit width_ok(input int unsigned w);
    if (w > MaxWidth) return 1'b0;
    return LegalWidthMask[w];
  endfunction

  function automatic int unsigned levels(input int unsigned w);
    return clog2(w);
  endfunction

endpackage

// File: rtl/sklansky_pipe_adder_if.sv
// Operand/result handshake bundle for sklansky_pipe_adder.
interface sklansky_pipe_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/sklansky_prefix_cell.sv
// Sklansky prefix operator: merges a high group (ph, gh) with the adjacent low group (pl, gl).
module sklansky_prefix_cell (
  input  logic ph,
  input  logic gh,
  input  logic pl,
  input  logic gl,
  output logic po,
  output logic go
);
  assign go = gh | (ph & gl);
  assign po = ph & pl;
endmodule

// File: rtl/sklansky_pipe_adder.sv
// Pipelined Sklansky prefix adder: PG register, one register per prefix level, output register.
// Optional signed overflow output enabled by defining SKLANSKY_OVF_EN.
module sklansky_pipe_adder
  import sklansky_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter bit          BP_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  sklansky_pipe_adder_if.slave bus
);
  localparam int unsigned LEVELS = levels(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("sklansky_pipe_adder: WIDTH must be 4, 8, 16, 32 or 64");
  end

  logic adv;

  // Index r holds the contents after stage r (0 = PG stage, r = prefix level r).
  logic [LEVELS:0]              v_q;
  logic [LEVELS:0]              ci_q;
  logic [LEVELS:0][WIDTH-1:0]   p_q;
  logic [LEVELS:0][WIDTH-1:0]   g_q;
  logic [LEVELS-1:0][WIDTH-1:0] pp_q;
  logic [LEVELS:1][WIDTH-1:0]   g_nx;
  logic [LEVELS:1][WIDTH-1:0]   pp_nx;

  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] sum_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             co_q;

  // Group propagates leaving the last level are never consumed.
  logic unused_pp;
  assign unused_pp = ^pp_nx[LEVELS];

  assign adv = BP_EN ? (~out_valid_q | bus.out_ready) : 1'b1;

  always_comb begin
    p0    = bus.a ^ bus.b;
    g0    = (bus.a & bus.b) | {{(WIDTH-1){1'b0}}, p0[0] & bus.ci};
    sum_d = p_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], ci_q[LEVELS]};
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> l) % 2) == 1) begin : g_cell
        localparam int J = ((i >> l) << l) - 1;
        sklansky_prefix_cell u_cell (
          .ph(pp_q[l][i]),
          .gh(g_q[l][i]),
          .pl(pp_q[l][J]),
          .gl(g_q[l][J]),
          .po(pp_nx[l+1][i]),
          .go(g_nx[l+1][i])
        );
      end else begin : g_pass
        assign g_nx[l+1][i]  = g_q[l][i];
        assign pp_nx[l+1][i] = pp_q[l][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      co_q        <= 1'b0;
    end else if (adv) begin
      v_q     <= {v_q[LEVELS-1:0], bus.in_valid};
      ci_q    <= {ci_q[LEVELS-1:0], bus.ci};
      p_q[0]  <= p0;
      g_q[0]  <= g0;
      pp_q[0] <= p0;
      for (int r = 1; r <= LEVELS; r++) begin
        p_q[r] <= p_q[r-1];
        g_q[r] <= g_nx[r];
      end
      for (int r = 1; r < LEVELS; r++) begin
        pp_q[r] <= pp_nx[r];
      end
      out_valid_q <= v_q[LEVELS];
      sum_q       <= sum_d;
      co_q        <= g_q[LEVELS][WIDTH-1];
    end
  end

`ifdef SKLANSKY_OVF_EN
  logic [LEVELS:0] sa_q;
  logic            ovf_q;

  // Operands share a sign iff the MSB propagate is 0; overflow then means sum MSB != that sign.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q  <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      sa_q  <= {sa_q[LEVELS-1:0], bus.a[WIDTH-1]};
      ovf_q <= ~p_q[LEVELS][WIDTH-1] & (sa_q[LEVELS] ^ g_q[LEVELS][WIDTH-2]);
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;

endmodule

// File: tb/tb_sklansky_pipe_adder.sv
// Self-checking bench for sklansky_pipe_adder at WIDTH 16 (back-pressure), 64 and 4 (no back-pressure).
module tb_sklansky_pipe_adder;

`ifdef SKLANSKY_OVF_EN
  localparam bit OvfOn = 1'b1;
`else
  localparam bit OvfOn = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] sum;
    logic        co;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ovf;
  } res16_t;

  typedef struct {
    logic [3:0] sum;
    logic       co;
  } res4_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   rand_rdy;

  res16_t sb16[$];
  res4_t  sb4[$];
  vec_t   tbl[8];

  sklansky_pipe_adder_if #(.WIDTH(16)) if16 ();
  sklansky_pipe_adder_if #(.WIDTH(64)) if64 ();
  sklansky_pipe_adder_if #(.WIDTH(4))  if4 ();

  sklansky_pipe_adder #(.WIDTH(16), .BP_EN(1'b1)) u16 (.clk(clk), .rst(rst), .bus(if16));
  sklansky_pipe_adder #(.WIDTH(64), .BP_EN(1'b1)) u64 (.clk(clk), .rst(rst), .bus(if64));
  sklansky_pipe_adder #(.WIDTH(4),  .BP_EN(1'b0)) u4  (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no-event", name);
  endtask

  function automatic res16_t model16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    res16_t r;
    logic [16:0] s;
    s     = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    r.sum = s[15:0];
    r.co  = s[16];
    r.ovf = OvfOn & (a[15] == b[15]) & (s[15] != a[15]);
    return r;
  endfunction

  function automatic res4_t model4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    res4_t r;
    logic [4:0] s;
    s     = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    r.sum = s[3:0];
    r.co  = s[4];
    return r;
  endfunction

  // One clock; the 16-bit consumer randomises its ready when enabled.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rand_rdy) if16.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic monitor();
    res16_t      e16;
    res4_t       e4;
    logic [15:0] hold_sum;
    logic        hold_co;
    logic        hold_ovf;
    bit          hold;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb16.delete();
        sb4.delete();
        hold = 1'b0;
      end else begin
        chk("in_ready16_rule", if16.in_ready, !(if16.out_valid && !if16.out_ready));
        if (hold) begin
          chk("stall_valid", if16.out_valid, 1);
          chk("stall_sum", if16.sum, hold_sum);
          chk("stall_co", if16.co, hold_co);
          chk("stall_ovf", if16.ovf, hold_ovf);
        end
        hold     = if16.out_valid && !if16.out_ready;
        hold_sum = if16.sum;
        hold_co  = if16.co;
        hold_ovf = if16.ovf;
        if (if16.in_valid && if16.in_ready) sb16.push_back(model16(if16.a, if16.b, if16.ci));
        if (if16.out_valid && if16.out_ready) begin
          if (sb16.size() == 0) flag("sb16_spurious_result");
          else begin
            e16 = sb16.pop_front();
            chk("sb16_sum", if16.sum, e16.sum);
            chk("sb16_co", if16.co, e16.co);
            chk("sb16_ovf", if16.ovf, e16.ovf);
          end
        end
        if (if4.in_valid) begin
          chk("in_ready4", if4.in_ready, 1);
          sb4.push_back(model4(if4.a, if4.b, if4.ci));
        end
        if (if4.out_valid) begin
          if (sb4.size() == 0) flag("sb4_spurious_result");
          else begin
            e4 = sb4.pop_front();
            chk("sb4_sum", if4.sum, e4.sum);
            chk("sb4_co", if4.co, e4.co);
          end
        end
      end
    end
  endtask

  task automatic apply16(input vec_t v, output int lat);
    if16.a        = v.a;
    if16.b        = v.b;
    if16.ci       = v.ci;
    if16.in_valid = 1'b1;
    cycle();
    if16.in_valid = 1'b0;
    lat = 1;
    while (!if16.out_valid && lat < 20) begin
      cycle();
      lat++;
    end
  endtask

  initial begin
    int   lat;
    int   n;
    bit   acc;
    vec_t v;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, 1'b0, 1'b1};

    checks   = 0;
    errors   = 0;
    rand_rdy = 1'b0;
    rst      = 1'b1;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.ci = 1'b0; if16.out_ready = 1'b1;
    if64.in_valid = 1'b0; if64.a = '0; if64.b = '0; if64.ci = 1'b0; if64.out_ready = 1'b1;
    if4.in_valid  = 1'b0; if4.a  = '0; if4.b  = '0; if4.ci  = 1'b0; if4.out_ready  = 1'b1;

    fork
      monitor();
    join_none

    repeat (3) cycle();
    chk("rst_out_valid16", if16.out_valid, 0);
    chk("rst_sum16", if16.sum, 0);
    chk("rst_co16", if16.co, 0);
    chk("rst_ovf16", if16.ovf, 0);
    chk("rst_out_valid64", if64.out_valid, 0);
    chk("rst_out_valid4", if4.out_valid, 0);
    rst = 1'b0;
    cycle();
    chk("in_ready_after_rst", if16.in_ready, 1);

    // Directed vectors: latency and exact results.
    for (int i = 0; i < 8; i++) begin
      apply16(tbl[i], lat);
      chk($sformatf("tbl%0d_latency", i), lat, 6);
      chk($sformatf("tbl%0d_sum", i), if16.sum, tbl[i].sum);
      chk($sformatf("tbl%0d_co", i), if16.co, tbl[i].co);
      chk($sformatf("tbl%0d_ovf", i), if16.ovf, tbl[i].ovf & OvfOn);
      cycle();
    end

    // 64-bit all-ones corner with carry-in.
    if64.a        = '1;
    if64.b        = '1;
    if64.ci       = 1'b1;
    if64.in_valid = 1'b1;
    cycle();
    if64.in_valid = 1'b0;
    lat = 1;
    while (!if64.out_valid && lat < 30) begin
      cycle();
      lat++;
    end
    chk("w64_latency", lat, 8);
    chk("w64_sum", if64.sum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_co", if64.co, 1);
    chk("w64_ovf", if64.ovf, 0);
    cycle();

    // Random back-to-back stream under random back-pressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if16.a        = 16'($urandom);
      if16.b        = 16'($urandom);
      if16.ci       = 1'($urandom_range(0, 1));
      if16.in_valid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
        @(negedge clk);
        acc = if16.in_ready;
        cycle();
        n++;
      end
      if (!acc) flag("rand_accept_timeout");
    end
    if16.in_valid = 1'b0;
    n = 0;
    while (sb16.size() != 0 && n < 300) begin
      cycle();
      n++;
    end
    chk("rand_drained", sb16.size(), 0);
    rand_rdy = 1'b0;
    if16.out_ready = 1'b1;
    repeat (8) cycle();
    chk("rand_no_extra", if16.out_valid, 0);

    // Reset with three operands in flight: none may ever emerge.
    for (int k = 0; k < 3; k++) begin
      v = tbl[k + 3];
      if16.a        = v.a;
      if16.b        = v.b;
      if16.ci       = v.ci;
      if16.in_valid = 1'b1;
      cycle();
    end
    if16.in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_in_ready", if16.in_ready, 1);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk($sformatf("midrst_out_valid_c%0d", k), if16.out_valid, 0);
    end

    // Exhaustive 4-bit sweep; out_ready toggles but must be ignored.
    for (int k = 0; k < 512; k++) begin
      if4.a         = k[3:0];
      if4.b         = k[7:4];
      if4.ci        = k[8];
      if4.in_valid  = 1'b1;
      if4.out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    if4.in_valid = 1'b0;
    repeat (8) cycle();
    chk("w4_drained", sb4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
